// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and defaults.
package arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick: first requester after 'last' (with wrap),
// optionally excluding one index (the current owner).
module arb_rr_pick
  import arbiter_pkg::*;
#(
  parameter  int N   = DEF_N,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  input  logic [IDW-1:0] mask_idx,
  input  logic           mask_en,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [N-1:0]   req_m;
  logic [N-1:0]   rot;
  logic [IDW-1:0] start;

  // Drop the excluded requester and find where the search begins.
  always_comb begin
    req_m = req;
    if (mask_en) req_m[mask_idx] = 1'b0;
    start = IDW'((int'(last) + 1) % N);
  end

  // Rotate so that bit 0 is the highest-priority requester this cycle.
  always_comb begin : rotate_blk
    logic [IDW-1:0] src;
    rot = '0;
    for (int j = 0; j < N; j++) begin
      src    = IDW'((int'(start) + j) % N);
      rot[j] = req_m[src];
    end
  end

  // Priority-encode the lowest set bit, then un-rotate back to a real index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        idx   = IDW'((int'(start) + j) % N);
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// N-way round-robin arbiter with grant hold and a hold-time preemption limit.
// Registered one-hot grant, encoded owner index and a preemption pulse.
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IDW      = $clog2(N),
  localparam int CNTW     = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           preempt
);

  state_t          state, state_n;
  logic [IDW-1:0]  last, last_n;
  logic [CNTW-1:0] hold_cnt, hold_cnt_n;
  logic [N-1:0]    gnt_n;
  logic [IDW-1:0]  gnt_id_n;
  logic            preempt_n;

  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic [N-1:0]    pick_onehot;
  logic            at_max;
  logic            owner_req;

  // In GRANT the owner is always masked: it either released (req=0 anyway)
  // or is being preempted and must not re-win.
  arb_rr_pick #(.N(N)) u_pick (
    .req      (req),
    .last     (last),
    .mask_idx (gnt_id),
    .mask_en  (state == ST_GRANT),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Helper decodes shared by the next-state logic.
  always_comb begin
    pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    at_max      = (hold_cnt == CNTW'(MAX_HOLD));
    owner_req   = req[gnt_id];
  end

  // Next-state and next-output decision.
  always_comb begin
    state_n    = state;
    last_n     = last;
    hold_cnt_n = hold_cnt;
    gnt_n      = gnt;
    gnt_id_n   = gnt_id;
    preempt_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_n    = ST_GRANT;
          gnt_n      = pick_onehot;
          gnt_id_n   = pick_idx;
          last_n     = pick_idx;
          hold_cnt_n = CNTW'(1);
        end
      end
      ST_GRANT: begin
        if (owner_req && (!at_max || !pick_found)) begin
          // Owner keeps the grant; the counter saturates when alone.
          if (!at_max) hold_cnt_n = hold_cnt + CNTW'(1);
        end else if (pick_found) begin
          // Either a preemption (owner still requesting) or a handover.
          preempt_n  = owner_req;
          gnt_n      = pick_onehot;
          gnt_id_n   = pick_idx;
          last_n     = pick_idx;
          hold_cnt_n = CNTW'(1);
        end else begin
          // Owner released and nobody else wants the resource; last keeps o.
          state_n    = ST_IDLE;
          gnt_n      = '0;
          gnt_id_n   = '0;
          hold_cnt_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      last      <= IDW'(N - 1);
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      hold_cnt  <= hold_cnt_n;
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      gnt_valid <= |gnt_n;
      preempt   <= preempt_n;
    end
  end

endmodule

// File: tb/tb_arbiter_rr.sv
// Randomized and directed bench for arbiter_rr against a behavioural model.
module tb_arbiter_rr;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = $clog2(N);

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           preempt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: owner index (-1 = nobody), last winner, hold length.
  int m_owner;
  int m_last;
  int m_hold;
  bit m_pre;

  arbiter_rr #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int from, input int excl);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (from + k) % N;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_hold  = 0;
    m_pre   = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    int p;
    bit others;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      p = model_pick(r, m_last, -1);
      if (p >= 0) begin
        m_owner = p; m_last = p; m_hold = 1;
      end
    end else begin
      others = 1'b0;
      for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others = 1'b1;
      if (r[m_owner] && (m_hold < MAX_HOLD || !others)) begin
        m_hold = (m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD;
      end else if (others) begin
        m_pre   = r[m_owner];
        p       = model_pick(r, m_last, m_owner);
        m_owner = p; m_last = p; m_hold = 1;
      end else begin
        m_owner = -1; m_hold = 0;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [N-1:0] exp_g;
    exp_g = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
    chk({tag, "_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    chk({tag, "_preempt"}, 32'(preempt), 32'(m_pre));
    if (m_owner >= 0) chk({tag, "_id"}, 32'(gnt_id), 32'(m_owner));
  endtask

  // Apply one request vector across one rising edge, then compare #1 later.
  task automatic step(input logic [N-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    reset = 1'b0;
    req   = 4'b1111;
    model_reset();

    // Reset holds outputs low even with all requests and running clock.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_preempt", 32'(preempt), 32'h0);
    #3;
    chk("rst_mid_gnt", 32'(gnt), 32'h0);
    req   = 4'b0000;
    reset = 1'b1;

    // Single request and release.
    step(4'b0001, "single");
    chk("single_gnt_const", 32'(gnt), 32'h1);
    chk("single_id_const", 32'(gnt_id), 32'h0);
    step(4'b0000, "single_drop");
    chk("single_drop_const", 32'(gnt), 32'h0);

    // Fairness: each owner drops after one cycle, order 0,1,2,3,0.
    do_reset();
    step(4'b1111, "fair0");
    chk("fair_id0", 32'(gnt_id), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      r = 4'b1111;
      r[gnt_id] = 1'b0;
      step(r, "fair");
      chk("fair_order", 32'(gnt_id), 32'(k % N));
      chk("fair_nobubble", 32'(gnt_valid), 32'h1);
    end

    // Preemption: req0 held, req2 joins after the grant.
    do_reset();
    step(4'b0001, "pre_g");
    for (int k = 0; k < 3; k++) begin
      step(4'b0101, "pre_hold");
      chk("pre_hold_const", 32'(gnt), 32'h1);
    end
    step(4'b0101, "pre_move");
    chk("pre_move_gnt", 32'(gnt), 32'h4);
    chk("pre_move_pulse", 32'(preempt), 32'h1);
    step(4'b0101, "pre_after");
    chk("pre_after_pulse", 32'(preempt), 32'h0);
    step(4'b0001, "pre_back");
    chk("pre_back_gnt", 32'(gnt), 32'h1);

    // Lone owner never times out; a newcomer preempts at once.
    step(4'b0000, "lone_idle");
    for (int k = 0; k < 20; k++) begin
      step(4'b0010, "lone");
      chk("lone_gnt", 32'(gnt), 32'h2);
      chk("lone_nopre", 32'(preempt), 32'h0);
    end
    step(4'b1010, "lone_pre");
    chk("lone_pre_gnt", 32'(gnt), 32'h8);
    chk("lone_pre_pulse", 32'(preempt), 32'h1);

    // Reset mid-grant clears between edges; arbitration restarts at 0.
    step(4'b0100, "mid_a");
    step(4'b0100, "mid_b");
    chk("mid_pre_gnt", 32'(gnt), 32'h4);
    #2 reset = 1'b0;
    #1;
    chk("mid_async_gnt", 32'(gnt), 32'h0);
    chk("mid_async_valid", 32'(gnt_valid), 32'h0);
    model_reset();
    #2 reset = 1'b1;
    step(4'b0110, "mid_restart");
    chk("mid_restart_gnt", 32'(gnt), 32'h2);

    // Random traffic, biased so owners often keep their request.
    for (int k = 0; k < 2000; k++) begin
      r = N'($urandom_range(0, (1 << N) - 1));
      if (gnt_valid && ($urandom_range(0, 3) != 0)) r[gnt_id] = 1'b1;
      step(r, "rand");
      chk("rand_onehot", 32'($onehot0(gnt)), 32'h1);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b0;
        #1;
        chk("rand_rst_gnt", 32'(gnt), 32'h0);
        model_reset();
        #2 reset = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
- N-way round-robin arbiter with grant hold and a hold-time limit; the scalable successor to the two-requester fixed arbiter.
- Shares one downstream resource (bus or port) between N requesters.
- A requester keeps its grant for as long as it holds its request. A hold counter preempts an owner that exceeds MAX_HOLD cycles while others are waiting.
- Registered one-hot grant plus an encoded owner index, for the datapath mux select.

Parameters:
- N, 4, number of requesters (≥2).
- MAX_HOLD, 8, maximum consecutive grant cycles before preemption when others wait (≥1).
- IDW, $clog2(N), width of gnt_id (derived; not overridden).
- CNTW, $clog2(MAX_HOLD+1), width of the hold counter (derived).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low (0 = reset asserted).
- req  in  N  request vector, bit i = requester i.
- gnt  out  N  registered one-hot grant; all-zero when idle.
- gnt_id  out  IDW  index of the current owner; valid only when gnt_valid=1.
- gnt_valid  out  1  OR of gnt (registered).
- preempt  out  1  one-cycle pulse on the edge where the grant is forcibly moved by hold expiry.

Behaviour:
- Reset is asynchronous and active-low: reset=0 forces every output immediately, independent of clk.
  - gnt=0, gnt_id=0, gnt_valid=0, preempt=0.
  - state=IDLE, hold_cnt=0, last=N-1 (so requester 0 wins first).
- Release is synchronous to clk; the first grant can occur at the first rising edge after reset=1.
- Invariant: at most one gnt bit is high. gnt_id and gnt_valid always agree with gnt.
- Pick function: the first i with req[i]=1, searching (last+1) mod N upward with wrap-around. Any subset of requesters is legal.
- State IDLE:
  - No req: stay; outputs stay zero.
  - Any req at edge k: gnt[pick]=1 from edge k (visible the cycle after req is sampled; 1-cycle latency); last←pick, hold_cnt←1, go to GRANT.
- State GRANT (owner o):
  - req[o]=1 and (hold_cnt<MAX_HOLD or no other req): keep grant. hold_cnt increments, saturating at MAX_HOLD.
  - req[o]=1, hold_cnt==MAX_HOLD, other req pending: preempt. The grant moves to pick (excluding o) on that edge; preempt=1 for one cycle; last←new owner; hold_cnt←1.
  - req[o]=0, others pending: zero-bubble handover to pick on that edge; last←new owner; hold_cnt←1; preempt stays 0.
  - req[o]=0, no others: gnt←0, go to IDLE. last keeps o.
- Simultaneous owner drop and new requests are resolved by the pick rule only. A dropped owner never re-wins on the same edge, because its req=0.
- Reset mid-GRANT: gnt clears asynchronously. After release, arbitration restarts from requester 0.
- The owner-alone case never times out. The counter saturates, and preemption happens on the first edge where another requester is present.

Decomposition:
- Package arbiter_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - default N and MAX_HOLD constants.
- Sub-module arb_rr_pick: purely combinational.
  - Inputs: req[N], last[IDW], mask_idx plus mask_en (excludes the current owner).
  - Outputs: found, idx[IDW].
  - Implemented as a rotate, priority-encode, un-rotate.
- arbiter_rr holds:
  - the state register, last, hold_cnt;
  - the output registers;
  - the preempt pulse.

Test Plan:
- Reset values: reset=0 with req=4'b1111 → gnt=0, gnt_valid=0, preempt=0. This holds between clock edges too, proving the reset is asynchronous.
- Single request: after reset, req=4'b0001 → gnt=4'b0001 and gnt_id=0 one cycle later. Drop req → gnt=0 the next cycle.
- Round-robin fairness: req=4'b1111, each owner dropping its req after 1 grant cycle and reasserting → grant order 0,1,2,3,0 with no idle cycle between owners.
- Preemption (MAX_HOLD=4): req0 held, req2 asserted after the grant.
  - gnt0 lasts exactly 4 cycles, then gnt=4'b0100 with preempt=1 for one cycle.
  - Next grant after req2 drops returns to 0.
- Lone owner: req1 held alone for 20 cycles → gnt stays 4'b0010, preempt never asserts.
  - Then raising req3 → grant moves to 3 on the next edge with preempt=1.
- Reset mid-grant: while gnt=4'b0100, pulse reset=0 between edges → gnt=0 immediately.
  - After release with req=4'b0110 → first grant goes to 1.
